mem_port_arbiter: RTL and testbench

- Sequences and shares the single unified instruction/data memory port between two requesters.
- Requester 0 is the CPU datapath, which issues fetch and load/store accesses currently steered by IorD.
- Requester 1 is a DMA/program-loader port used for test preload and debug readback.
- Exactly one access is in flight at a time; the block owns all memory control and address/data outputs and returns per-requester acknowledge and read data.

---
 rtl/mem_port_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares the single unified instruction/data memory port between the CPU
// datapath (requester 0) and the DMA/program-loader port (requester 1).
// One access is in flight at a time: IDLE -> ACCESS -> [WAIT] -> DONE -> IDLE.
// All memory-side outputs, acks and read-data registers are registered.
module mem_port_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int RD_LAT   = 1,
   parameter int CPU_PRIO = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic          dma_ack,
   output logic [DW-1:0] dma_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
);

   localparam int CNT_W = $clog2(RD_LAT + 1);

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             owner_q, owner_d;
   logic             last_grant_q, last_grant_d;
   logic             mem_en_q, mem_en_d;
   logic             mem_we_q, mem_we_d;
   logic [AW-1:0]    mem_addr_q, mem_addr_d;
   logic [DW-1:0]    mem_wdata_q, mem_wdata_d;
   logic             cpu_ack_q, cpu_ack_d;
   logic             dma_ack_q, dma_ack_d;
   logic [DW-1:0]    cpu_rdata_q, cpu_rdata_d;
   logic [DW-1:0]    dma_rdata_q, dma_rdata_d;
   logic             grant_dma_s;

   // Choose the winner among pending requests; only acted on in IDLE.
   always_comb begin
      grant_dma_s = 1'b0;
      if (cpu_req && dma_req) begin
         if (CPU_PRIO != 32'sd0) begin
            grant_dma_s = 1'b0;
         end else begin
            // Round-robin: the side that was not served last wins the tie.
            grant_dma_s = (last_grant_q == OWN_CPU);
         end
      end else begin
         grant_dma_s = dma_req;
      end
   end

   // Next-state and registered-output logic of the access sequencer.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_grant_d = last_grant_q;
      mem_en_d     = 1'b0;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      cpu_ack_d    = 1'b0;
      dma_ack_d    = 1'b0;
      cpu_rdata_d  = cpu_rdata_q;
      dma_rdata_d  = dma_rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (cpu_req || dma_req) begin
               owner_d  = grant_dma_s;
               mem_en_d = 1'b1;
               if (grant_dma_s) begin
                  mem_we_d    = dma_we;
                  mem_addr_d  = dma_addr;
                  mem_wdata_d = dma_wdata;
               end else begin
                  mem_we_d    = cpu_we;
                  mem_addr_d  = cpu_addr;
                  mem_wdata_d = cpu_wdata;
               end
               state_d = ST_ACCESS;
            end else begin
               mem_we_d = 1'b0;
            end
         end
         ST_ACCESS: begin
            if (mem_we_q) begin
               // Writes complete without waiting on the memory.
               cpu_ack_d = (owner_q == OWN_CPU);
               dma_ack_d = (owner_q == OWN_DMA);
               state_d   = ST_DONE;
            end else begin
               cnt_d   = CNT_W'(RD_LAT);
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
               // Last wait cycle: mem_rdata is valid now.
               if (owner_q == OWN_DMA) begin
                  dma_rdata_d = mem_rdata;
               end else begin
                  cpu_rdata_d = mem_rdata;
               end
               cpu_ack_d = (owner_q == OWN_CPU);
               dma_ack_d = (owner_q == OWN_DMA);
               state_d   = ST_DONE;
            end else begin
               state_d = ST_WAIT;
            end
         end
         ST_DONE: begin
            last_grant_d = owner_q;
            mem_we_d     = 1'b0;
            state_d      = ST_IDLE;
         end
         default: begin
            mem_we_d = 1'b0;
            state_d  = ST_IDLE;
         end
      endcase
   end

   // State and output registers; reset abandons any access in flight.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         owner_q      <= OWN_CPU;
         last_grant_q <= OWN_DMA;
         mem_en_q     <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         cpu_ack_q    <= 1'b0;
         dma_ack_q    <= 1'b0;
         cpu_rdata_q  <= '0;
         dma_rdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_grant_q <= last_grant_d;
         mem_en_q     <= mem_en_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_ack_q    <= cpu_ack_d;
         dma_ack_q    <= dma_ack_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_ack   = cpu_ack_q;
   assign dma_ack   = dma_ack_q;
   assign cpu_rdata = cpu_rdata_q;
   assign dma_rdata = dma_rdata_q;
   assign busy      = (state_q != ST_IDLE);
   assign cpu_stall = cpu_req & ~cpu_ack_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Two arbiter instances share one clock:
//   instance 0: RD_LAT=1, round-robin
//   instance 1: RD_LAT=3, CPU fixed priority
// A bench memory returns valid read data only in the cycle exactly RD_LAT
// cycles after the strobe, so early or late capture shows up as bad data.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   logic [1:0] rst;
   logic [1:0] cpu_req, cpu_we, dma_req, dma_we;
   logic [1:0][31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic [1:0][31:0] mem_rdata;
   wire  [1:0] cpu_ack, cpu_stall, dma_ack, mem_en, mem_we, busy;
   wire  [1:0][31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;

   int n_checks = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .CPU_PRIO(0)) u_dut0 (
      .clk(clk), .rst(rst[0]),
      .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]), .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]),
      .cpu_ack(cpu_ack[0]), .cpu_rdata(cpu_rdata[0]), .cpu_stall(cpu_stall[0]),
      .dma_req(dma_req[0]), .dma_we(dma_we[0]), .dma_addr(dma_addr[0]), .dma_wdata(dma_wdata[0]),
      .dma_ack(dma_ack[0]), .dma_rdata(dma_rdata[0]),
      .mem_en(mem_en[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]),
      .mem_rdata(mem_rdata[0]), .busy(busy[0]));

   mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .CPU_PRIO(1)) u_dut1 (
      .clk(clk), .rst(rst[1]),
      .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]), .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]),
      .cpu_ack(cpu_ack[1]), .cpu_rdata(cpu_rdata[1]), .cpu_stall(cpu_stall[1]),
      .dma_req(dma_req[1]), .dma_we(dma_we[1]), .dma_addr(dma_addr[1]), .dma_wdata(dma_wdata[1]),
      .dma_ack(dma_ack[1]), .dma_rdata(dma_rdata[1]),
      .mem_en(mem_en[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]),
      .mem_rdata(mem_rdata[1]), .busy(busy[1]));

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 3;
   endfunction

   function automatic bit prio_of(input int k);
      return (k == 1);
   endfunction

   // Bench memory: 256 words per instance, writes land on the strobe edge.
   bit [31:0] pmem [2][256];
   int age [2];

   // Track cycles since the last strobe and perform writes.
   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (mem_en[k]) begin
            age[k] <= 1;
            if (mem_we[k]) pmem[k][mem_addr[k][7:0]] <= mem_wdata[k];
         end else if (age[k] != 0) begin
            age[k] <= age[k] + 1;
         end
      end
   end

   // Read data is valid only RD_LAT cycles after the strobe; garbage otherwise.
   always_comb begin
      for (int k = 0; k < 2; k++) begin
         if (age[k] == lat_of(k)) mem_rdata[k] = pmem[k][mem_addr[k][7:0]];
         else mem_rdata[k] = 32'hBAD0_0000 | 32'(age[k]);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h", name, act, exp);
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      chk(name, {31'd0, act}, {31'd0, exp});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int k, input bit dma, input bit req, input bit we,
                          input logic [31:0] a, input logic [31:0] d);
      if (dma) begin
         dma_req[k] = req; dma_we[k] = we; dma_addr[k] = a; dma_wdata[k] = d;
      end else begin
         cpu_req[k] = req; cpu_we[k] = we; cpu_addr[k] = a; cpu_wdata[k] = d;
      end
   endtask

   task automatic check_zero(input int k);
      chk1("rst_cpu_ack", cpu_ack[k], 1'b0);
      chk1("rst_dma_ack", dma_ack[k], 1'b0);
      chk1("rst_mem_en", mem_en[k], 1'b0);
      chk1("rst_mem_we", mem_we[k], 1'b0);
      chk1("rst_busy", busy[k], 1'b0);
      chk("rst_mem_addr", mem_addr[k], 32'h0);
      chk("rst_mem_wdata", mem_wdata[k], 32'h0);
      chk("rst_cpu_rdata", cpu_rdata[k], 32'h0);
      chk("rst_dma_rdata", dma_rdata[k], 32'h0);
   endtask

   typedef struct {
      int          k;
      bit          dma;
      bit          we;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          ack_cyc;
      logic [31:0] rdata;
   } vec_t;

   vec_t vecs [8];

   // Transaction-level reference model state for the random phase.
   int          m_free [2], m_ack [2], m_en [2];
   bit          m_who [2], m_we [2], m_rd [2], m_last [2];
   logic [31:0] m_addr [2], m_wd [2], m_data [2];
   logic [31:0] m_rdata [2][2];
   bit   [31:0] ref_mem [2][16];
   bit          act [2][2], granted [2][2], dropped [2][2];
   int          ackc [2][2];
   bit          p_we [2][2];
   logic [31:0] p_addr [2][2], p_wd [2][2];

   initial begin
      vec_t v;
      int   done_cnt;
      bit   w;

      // {instance, dma, we, addr, wdata, ack cycle, rdata at ack}
      vecs[0] = '{0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 2, 32'h0};
      vecs[1] = '{0, 1'b0, 1'b0, 32'h10, 32'h0,        3, 32'hDEADBEEF};
      vecs[2] = '{0, 1'b1, 1'b1, 32'h40, 32'h12345678, 2, 32'h0};
      vecs[3] = '{0, 1'b1, 1'b0, 32'h40, 32'h0,        3, 32'h12345678};
      vecs[4] = '{0, 1'b0, 1'b1, 32'h44, 32'hCAFEF00D, 2, 32'hDEADBEEF};
      vecs[5] = '{1, 1'b0, 1'b1, 32'h20, 32'hA5A55A5A, 2, 32'h0};
      vecs[6] = '{1, 1'b0, 1'b0, 32'h20, 32'h0,        5, 32'hA5A55A5A};
      vecs[7] = '{1, 1'b1, 1'b0, 32'h20, 32'h0,        5, 32'hA5A55A5A};

      rst = 2'b00;
      cpu_req = '0; cpu_we = '0; cpu_addr = '0; cpu_wdata = '0;
      dma_req = '0; dma_we = '0; dma_addr = '0; dma_wdata = '0;
      #2;
      check_zero(0);
      check_zero(1);
      tick();
      tick();
      rst = 2'b11;

      // Single transactions from the table.
      for (int i = 0; i < 8; i++) begin
         v = vecs[i];
         set_req(v.k, v.dma, 1'b1, v.we, v.addr, v.wdata);
         #1;
         if (!v.dma) chk1("vec_stall_c0", cpu_stall[v.k], 1'b1);
         for (int c = 1; c <= v.ack_cyc + 1; c++) begin
            tick();
            chk1("vec_mem_en", mem_en[v.k], c == 1);
            if (c == 1) begin
               chk1("vec_mem_we", mem_we[v.k], v.we);
               chk("vec_mem_addr", mem_addr[v.k], v.addr);
               if (v.we) chk("vec_mem_wdata", mem_wdata[v.k], v.wdata);
            end
            chk1("vec_cpu_ack", cpu_ack[v.k], !v.dma && (c == v.ack_cyc));
            chk1("vec_dma_ack", dma_ack[v.k], v.dma && (c == v.ack_cyc));
            chk1("vec_busy", busy[v.k], c <= v.ack_cyc);
            if (c == v.ack_cyc) begin
               chk("vec_rdata", v.dma ? dma_rdata[v.k] : cpu_rdata[v.k], v.rdata);
               if (v.we) chk("vec_mem_word", pmem[v.k][v.addr[7:0]], v.wdata);
               set_req(v.k, v.dma, 1'b0, 1'b0, 32'h0, 32'h0);
            end
            if (!v.dma) begin
               #1;
               chk1("vec_stall", cpu_stall[v.k], c < v.ack_cyc);
            end
         end
      end

      // Reset during the WAIT cycle of a DMA read on instance 0.
      set_req(0, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0);
      tick();
      chk1("rw_mem_en_access", mem_en[0], 1'b1);
      tick();
      chk1("rw_busy_wait", busy[0], 1'b1);
      rst[0] = 1'b0;
      #1;
      check_zero(0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk1("rw_no_dma_ack", dma_ack[0], 1'b0);
         chk1("rw_busy_in_rst", busy[0], 1'b0);
      end
      // Tie right after release: CPU first, then the reissued DMA read; alternate.
      set_req(0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
      rst[0] = 1'b1;
      done_cnt = 0;
      for (int c = 1; c <= 16; c++) begin
         tick();
         chk1("alt_cpu_ack", cpu_ack[0], (c % 4 == 3) && ((c / 4) % 2 == 0));
         chk1("alt_dma_ack", dma_ack[0], (c % 4 == 3) && ((c / 4) % 2 == 1));
         chk1("alt_one_ack", cpu_ack[0] & dma_ack[0], 1'b0);
         chk1("alt_mem_en", mem_en[0], c % 4 == 1);
         if (c % 4 == 1) chk("alt_mem_addr", mem_addr[0], ((c / 4) % 2 == 0) ? 32'h10 : 32'h40);
         if (cpu_ack[0]) chk("alt_cpu_rdata", cpu_rdata[0], 32'hDEADBEEF);
         if (dma_ack[0]) chk("alt_dma_rdata", dma_rdata[0], 32'h12345678);
         if (cpu_ack[0] || dma_ack[0]) done_cnt++;
         if (c == 16) begin
            set_req(0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
            set_req(0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
         end
      end
      chk("alt_completions", 32'(done_cnt), 32'd4);
      tick();
      chk1("alt_idle_after", busy[0], 1'b0);

      // Fixed CPU priority on instance 1 with both requesters always asking.
      set_req(1, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
      set_req(1, 1'b1, 1'b1, 1'b0, 32'h20, 32'h0);
      for (int c = 1; c <= 24; c++) begin
         tick();
         chk1("prio_cpu_ack", cpu_ack[1], (c <= 17) && (c % 6 == 5));
         chk1("prio_dma_ack", dma_ack[1], c == 23);
         chk1("prio_mem_en", mem_en[1], ((c <= 13) && (c % 6 == 1)) || (c == 19));
         if (cpu_ack[1]) chk("prio_cpu_rdata", cpu_rdata[1], 32'hA5A55A5A);
         if (dma_ack[1]) chk("prio_dma_rdata", dma_rdata[1], 32'hA5A55A5A);
         if (c == 18) set_req(1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         if (c == 23) set_req(1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      end

      // Random traffic on both instances against the transaction-level model.
      rst = 2'b00;
      cpu_req = '0;
      dma_req = '0;
      #1;
      check_zero(0);
      check_zero(1);
      tick();
      tick();
      rst = 2'b11;
      for (int k = 0; k < 2; k++) begin
         m_free[k] = 0; m_ack[k] = -1; m_en[k] = -1; m_last[k] = 1'b1;
         for (int r = 0; r < 2; r++) begin
            m_rdata[k][r] = 32'h0; act[k][r] = 1'b0; granted[k][r] = 1'b0;
         end
      end
      for (int c = 0; c < 1500; c++) begin
         if (c > 0) begin
            tick();
            for (int k = 0; k < 2; k++) begin
               if (m_ack[k] == c && m_rd[k]) m_rdata[k][m_who[k]] = m_data[k];
               chk1("rnd_cpu_ack", cpu_ack[k], (m_ack[k] == c) && !m_who[k]);
               chk1("rnd_dma_ack", dma_ack[k], (m_ack[k] == c) && m_who[k]);
               chk1("rnd_mem_en", mem_en[k], m_en[k] == c);
               chk1("rnd_busy", busy[k], (c >= m_en[k]) && (c <= m_ack[k]));
               if (m_en[k] == c) begin
                  chk1("rnd_mem_we", mem_we[k], m_we[k]);
                  chk("rnd_mem_addr", mem_addr[k], m_addr[k]);
                  if (m_we[k]) chk("rnd_mem_wdata", mem_wdata[k], m_wd[k]);
               end
               chk("rnd_cpu_rdata", cpu_rdata[k], m_rdata[k][0]);
               chk("rnd_dma_rdata", dma_rdata[k], m_rdata[k][1]);
            end
         end
         for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 2; r++) begin
               if (act[k][r] && granted[k][r] && ackc[k][r] < c) act[k][r] = 1'b0;
               if (!act[k][r]) begin
                  if ($urandom_range(0, 2) == 0) begin
                     act[k][r] = 1'b1; granted[k][r] = 1'b0; dropped[k][r] = 1'b0;
                     p_we[k][r] = 1'($urandom_range(0, 1));
                     p_addr[k][r] = 32'h80 + 32'($urandom_range(0, 15));
                     p_wd[k][r] = $urandom;
                     set_req(k, r[0], 1'b1, p_we[k][r], p_addr[k][r], p_wd[k][r]);
                  end else begin
                     set_req(k, r[0], 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
                  end
               end else if (granted[k][r] && !dropped[k][r] && ackc[k][r] > c &&
                            $urandom_range(0, 4) == 0) begin
                  // Drop the request mid-access and scramble the latched fields.
                  dropped[k][r] = 1'b1;
                  set_req(k, r[0], 1'b0, 1'($urandom_range(0, 1)), $urandom, $urandom);
               end
            end
            if (c >= m_free[k] && (cpu_req[k] || dma_req[k])) begin
               if (cpu_req[k] && dma_req[k]) w = prio_of(k) ? 1'b0 : !m_last[k];
               else w = dma_req[k];
               granted[k][w] = 1'b1;
               m_who[k]  = w;
               m_we[k]   = p_we[k][w];
               m_addr[k] = p_addr[k][w];
               m_wd[k]   = p_wd[k][w];
               m_rd[k]   = !p_we[k][w];
               m_en[k]   = c + 1;
               m_ack[k]  = c + (p_we[k][w] ? 2 : 2 + lat_of(k));
               m_free[k] = m_ack[k] + 1;
               ackc[k][w] = m_ack[k];
               m_last[k] = w;
               if (p_we[k][w]) ref_mem[k][p_addr[k][w][3:0]] = p_wd[k][w];
               else m_data[k] = ref_mem[k][p_addr[k][w][3:0]];
            end
         end
         #1;
         for (int k = 0; k < 2; k++) begin
            chk1("rnd_cpu_stall", cpu_stall[k], cpu_req[k] && !((m_ack[k] == c) && !m_who[k]));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
